game_flow_ctrl: RTL

Parametrised game-flow sequencer for N players: title screen, per-level play, death/win screens, level advance and level-object revive. It replaces the fixed two-player gameover/gamewin controller, combining per-player dead/win vectors internally. Clocked by the 50 MHz system clock, advanced by a per-frame tick, and drives the revive pulse consumed by the score, elevator and water controllers plus the freeze/overlay signals used by the players and colour mapper.

---
 rtl/game_flow_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: title, load, play, dead/win screens and done, for N players.
// Drives the level-object revive pulse plus the freeze/overlay signals for the display path.
module game_flow_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LEVELS  = 4,
  parameter int DEAD_FRAMES = 120,
  parameter int WIN_FRAMES  = 180,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic                   confirm,
  input  logic [NUM_PLAYERS-1:0] player_dead,
  input  logic [NUM_PLAYERS-1:0] player_win,
  output logic [2:0]             state,
  output logic                   revive,
  output logic [LW-1:0]          level,
  output logic                   freeze,
  output logic [1:0]             overlay,
  output logic [7:0]             deaths
);

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_DEAD  = 3'd3,
    S_WIN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [15:0]   DEAD_LAST  = 16'(DEAD_FRAMES - 1);
  localparam logic [15:0]   WIN_LAST   = 16'(WIN_FRAMES - 1);
  localparam logic [LW-1:0] LEVEL_LAST = LW'(NUM_LEVELS - 1);

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    deaths_q, deaths_d;
  logic [15:0]   timer_q, timer_d;
  logic          confirm_q;
  logic          cf_rise, any_dead, all_win;
  logic          dead_expire, win_expire;

  assign cf_rise     = confirm & ~confirm_q;
  assign any_dead    = |player_dead;
  assign all_win     = &player_win;
  assign dead_expire = frame_tick && (timer_q == DEAD_LAST);
  assign win_expire  = frame_tick && (timer_q == WIN_LAST);

  // confirm_q resets high so a key held through reset release cannot start a game
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_TITLE;
      level_q   <= '0;
      deaths_q  <= '0;
      timer_q   <= '0;
      confirm_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      deaths_q  <= deaths_d;
      timer_q   <= timer_d;
      confirm_q <= confirm;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    deaths_d = deaths_q;
    timer_d  = timer_q;
    case (state_q)
      S_TITLE: begin
        if (cf_rise) begin
          state_d  = S_LOAD;
          level_d  = '0;
          deaths_d = '0;
        end
      end
      S_LOAD: state_d = S_PLAY;
      S_PLAY: begin
        if (any_dead) begin
          state_d = S_DEAD;
          if (deaths_q != 8'hFF) deaths_d = deaths_q + 8'd1;
        end else if (all_win) begin
          state_d = S_WIN;
        end
      end
      S_DEAD: begin
        if (cf_rise || dead_expire) state_d = S_LOAD;
        else if (frame_tick)        timer_d = timer_q + 16'd1;
      end
      S_WIN: begin
        if (cf_rise || win_expire) begin
          if (level_q == LEVEL_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            level_d = level_q + LW'(1);
          end
        end else if (frame_tick) begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_DONE: begin
        if (cf_rise) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase
    // every state entry starts the frame timer from zero
    if (state_d != state_q) timer_d = '0;
  end

  always_comb begin
    overlay = 2'd0;
    case (state_q)
      S_TITLE, S_DONE: overlay = 2'd1;
      S_DEAD:          overlay = 2'd2;
      S_WIN:           overlay = 2'd3;
      default:         overlay = 2'd0;
    endcase
  end

  assign state  = state_q;
  assign revive = (state_q == S_LOAD);
  assign freeze = (state_q != S_PLAY);
  assign level  = level_q;
  assign deaths = deaths_q;

endmodule
